// File: rtl/mmu_video_fetch.sv
`default_nettype none
// ==== mmu_video_fetch : video DMA prefetch FIFO and shifter load strobe (rev 1.0) ====
// ==== Define COUNTER_WRITE_EN to make the video counter bytes CPU-writable.          ====
module mmu_video_fetch #(
    parameter int ADDR_W      = 22,
    parameter int FIFO_DEPTH  = 4,
    parameter int LOAD_PERIOD = 16
) (
    input  logic              CLOCK_32,
    input  logic              RESET_N,
    input  logic              cs,
    input  logic              rw,
    input  logic [4:0]        addr,
    input  logic [15:0]       din,
    output logic [15:0]       dout,
    output logic              oe,
    input  logic              vsync,
    input  logic              de,
    output logic              load,
    output logic [15:0]       sh_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic              underrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PH_W  = (LOAD_PERIOD > 1) ? $clog2(LOAD_PERIOD) : 1;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_vsync, r_de, r_discard, r_underrun;
    logic [7:0]        r_base_hi, r_base_mid;
    logic [ADDR_W-1:0] r_counter, r_mem_addr, w_counter_nxt;
    logic [15:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wp, r_rp;
    logic [CNT_W-1:0]  r_count;
    logic [PH_W-1:0]   r_phase;
    logic [15:0]       r_sh_data;
    logic [23:0]       w_cnt24;
    logic              w_wr, w_vs_rise, w_cnt_wr, w_flush, w_ack, w_push, w_pass;
    logic              w_load, w_empty, w_full, w_pop, w_unused;

    assign w_wr      = cs & ~rw;
    assign w_vs_rise = vsync & ~r_vsync;
`ifdef COUNTER_WRITE_EN
    assign w_cnt_wr  = w_wr & ((addr == 5'd2) | (addr == 5'd3) | (addr == 5'd4));
`else
    assign w_cnt_wr  = 1'b0;
`endif
    assign w_flush   = w_vs_rise | w_cnt_wr;
    assign w_ack     = (r_state == S_REQ) & mem_ack;
    assign w_push    = w_ack & ~r_discard & ~w_flush;
    assign w_load    = r_de & (r_phase == '0);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop     = w_load & ~w_empty;
    assign w_pass    = w_load & w_empty & w_push;
    assign w_cnt24   = 24'(r_counter);
    assign w_unused  = ^din[15:8];

    assign load     = w_load;
    assign mem_req  = (r_state == S_REQ);
    assign mem_addr = r_mem_addr;
    assign sh_data  = r_sh_data;
    assign underrun = r_underrun;

    // Priority: CPU counter write > vsync reload > post-ack increment.
`ifdef COUNTER_WRITE_EN
    logic [23:0] w_cnt24_wr;
`endif
    always_comb begin
        w_counter_nxt = r_counter;
        if (w_ack && !r_discard)
            w_counter_nxt = r_counter + ADDR_W'(2);
        if (w_vs_rise)
            w_counter_nxt = ADDR_W'({r_base_hi, r_base_mid, 8'h00});
`ifdef COUNTER_WRITE_EN
        w_cnt24_wr = w_cnt24;
        case (addr)
            5'd2:    w_cnt24_wr[23:16] = din[7:0];
            5'd3:    w_cnt24_wr[15:8]  = din[7:0];
            5'd4:    w_cnt24_wr[7:0]   = {din[7:1], 1'b0};
            default: ;
        endcase
        if (w_cnt_wr)
            w_counter_nxt = ADDR_W'(w_cnt24_wr);
`endif
    end

    // Fetching is held off in a flush cycle so the captured address is the new one.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!w_full && !w_flush) w_state_nxt = S_REQ;
            S_REQ:   if (mem_ack) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_32 or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge CLOCK_32 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_vsync    <= 1'b0;
            r_de       <= 1'b0;
            r_base_hi  <= 8'h00;
            r_base_mid <= 8'h00;
            r_counter  <= '0;
            r_mem_addr <= '0;
            r_discard  <= 1'b0;
            r_phase    <= '0;
        end else begin
            r_vsync   <= vsync;
            r_de      <= de;
            r_counter <= w_counter_nxt;
            if (w_wr && addr == 5'd0) r_base_hi  <= din[7:0];
            if (w_wr && addr == 5'd1) r_base_mid <= din[7:0];
            if (r_state == S_IDLE && w_state_nxt == S_REQ)
                r_mem_addr <= r_counter;
            if (w_ack)
                r_discard <= 1'b0;
            else if (w_flush && r_state == S_REQ)
                r_discard <= 1'b1;
            if (!r_de)
                r_phase <= '0;
            else if (r_phase == PH_W'(LOAD_PERIOD - 1))
                r_phase <= '0;
            else
                r_phase <= r_phase + PH_W'(1);
        end
    end

    always_ff @(posedge CLOCK_32) begin
        if (w_push && !w_pass && !w_flush)
            r_fifo[r_wp] <= mem_rdata;
    end

    always_ff @(posedge CLOCK_32 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push && !w_pass) r_wp <= r_wp + PTR_W'(1);
            if (w_pop)             r_rp <= r_rp + PTR_W'(1);
            case ({w_push && !w_pass, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_32 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sh_data  <= 16'h0000;
            r_underrun <= 1'b0;
        end else begin
            if (w_load) begin
                if (!w_empty)    r_sh_data <= r_fifo[r_rp];
                else if (w_push) r_sh_data <= mem_rdata;
                else             r_sh_data <= 16'h0000;
            end
            if (w_load && w_empty && !w_push)
                r_underrun <= 1'b1;
            else if (w_wr && addr == 5'd5)
                r_underrun <= 1'b0;
        end
    end

    always_comb begin
        oe   = 1'b0;
        dout = 16'h0000;
        if (cs && rw) begin
            case (addr)
                5'd0:    begin oe = 1'b1; dout = {8'h00, r_base_hi};      end
                5'd1:    begin oe = 1'b1; dout = {8'h00, r_base_mid};     end
                5'd2:    begin oe = 1'b1; dout = {8'h00, w_cnt24[23:16]}; end
                5'd3:    begin oe = 1'b1; dout = {8'h00, w_cnt24[15:8]};  end
                5'd4:    begin oe = 1'b1; dout = {8'h00, w_cnt24[7:0]};   end
                5'd5:    begin oe = 1'b1; dout = {15'd0, r_underrun};     end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mmu_video_fetch.md
Name: mmu_video_fetch

Overview:
Video DMA front end that feeds the shifter's load/data input. It holds the CPU-visible video base and counter registers, prefetches screen words from RAM into a small FIFO over a req/ack memory port, and presents one word per load strobe while display enable is high. It sits between the RAM arbiter and the shifter and runs entirely on CLOCK_32.

Parameters:
ADDR_W, 22, byte address width of the memory port; bit 0 is always 0.
FIFO_DEPTH, 4, prefetch FIFO depth in 16-bit words; must be a power of 2 and at least 2.
LOAD_PERIOD, 16, CLOCK_32 cycles between successive load strobes while de is high.

Ports:
CLOCK_32  in  1  system clock.
RESET_N  in  1  asynchronous active-low reset.
cs  in  1  register select from CPU bus decode.
rw  in  1  1 = read, 0 = write.
addr  in  5  register word index.
din  in  16  CPU write data.
dout  out  16  CPU read data.
oe  out  1  high when dout must be driven onto the CPU bus (cs & rw & valid addr).
vsync  in  1  vertical sync, active high.
de  in  1  display enable from the timing generator.
load  out  1  one-cycle strobe to the shifter; word valid on sh_data.
sh_data  out  16  screen word to the shifter; held between loads.
mem_req  out  1  memory read request.
mem_addr  out  ADDR_W  byte address; stable while mem_req is high.
mem_ack  in  1  one-cycle acknowledge; mem_rdata is valid in the same cycle.
mem_rdata  in  16  memory read data.
underrun  out  1  sticky flag: a load occurred with the FIFO empty.

Behaviour:
- Reset values: all outputs 0; base_hi, base_mid, counter 0; FIFO empty; fetch FSM in IDLE; phase counter 0.
- Registers are written when cs & !rw, in the cycle they are presented. Write data is din[7:0].
  - addr 0: base_hi (R/W).
  - addr 1: base_mid (R/W).
  - addr 2, 3, 4: counter bits [23:16], [15:8], [7:0] (read-only; bits above ADDR_W-1 read 0).
  - addr 5: bit 0 = underrun, read-only. A write of any value clears underrun.
  - Unused addresses read 0 and have oe = 0.
- Read format: dout = {8'h00, reg}, combinational.
- vsync edge detection: vsync is registered and its rising edge is detected.
  - On the rising edge: counter <= {base_hi, base_mid, 8'h00} truncated to ADDR_W bits, the FIFO is flushed, and any returning in-flight word is discarded.
  - If the edge coincides with a push, the flush wins.
- Fetch FSM has two states.
  - IDLE -> REQ when the FIFO is not full (counting the in-flight slot) and no reload is pending.
  - REQ holds mem_req = 1 and mem_addr = counter until mem_ack.
  - On mem_ack: push mem_rdata unless discard is set, counter += 2 (wrapping at 2^ADDR_W to 0), and return to IDLE.
  - There is a minimum of 1 IDLE cycle between requests.
  - A vsync edge during REQ does not drop mem_req. The transaction completes, the word is discarded, the counter is not incremented, and the reload applies.
- Load generation uses a registered de.
  - On the first cycle de_r is high, load = 1. Further loads follow every LOAD_PERIOD cycles while de_r stays high.
  - When de_r goes low, the phase counter resets to 0.
  - On load with the FIFO non-empty: pop the FIFO and drive sh_data with that word.
  - On load with the FIFO empty: sh_data <= 16'h0000 and underrun <= 1.
  - A simultaneous push and pop on a full or empty FIFO is legal: occupancy is unchanged, or the word passes through on empty.
- Reset asserted mid-transaction drops mem_req immediately (asynchronous reset).

Optional Feature:
COUNTER_WRITE_EN.
- With the macro defined: addr 2, 3, 4 become writable. A write replaces the addressed counter byte (bit 0 forced to 0), flushes the FIFO, and sets discard on any in-flight word. If the write coincides with a vsync reload, the CPU write wins.
- Without the macro: those addresses are read-only and writes are ignored.

Test Plan:
- Reset: assert RESET_N = 0 mid-REQ -> mem_req, load, sh_data, dout, underrun are all 0 asynchronously; counter reads 0.
- Write base_hi = 0x12, base_mid = 0x34, then pulse vsync -> first mem_addr = 0x123400, next 0x123402; counter reads 0x12/0x34/0x04 after 2 acks. FIFO fills to 4 words, then mem_req stays low.
- Preload the FIFO with 0xA001..0xA004, raise de for 64 cycles -> load pulses at cycles 1, 17, 33, 49 after de rises; sh_data = 0xA001..0xA004 in order, underrun = 0.
- Hold mem_ack low, raise de -> FIFO drains, then the 5th load gives sh_data = 0x0000 and underrun = 1. A read of addr 5 returns 0x0001; a write to addr 5 clears it.
- Base 0x3F/0xFF, vsync -> addresses run 0x3FFF00 ... 0x3FFFFE, then wrap to 0x000000.
- vsync edge while mem_req is high -> mem_req stays high until ack, the word is not pushed, and the next mem_addr = the new base. With COUNTER_WRITE_EN, write 0x56 to addr 4 -> next mem_addr low byte = 0x56 and the FIFO is empty.
